// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through FIFO onto a UART-style serial line:
// start bit, data LSB first, optional even parity, stop bit.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         clk_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_bit;
  logic                  bit_end;
  logic                  pop;

  assign bit_end = (clk_cnt == CNT_LAST);

  // A new word may be taken when idle or in the final stop cycle, so frames chain with no gap.
  assign pop       = enable & ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign fifo_r_en = rst_n & pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        state      <= START;
        clk_cnt    <= '0;
        shreg      <= fifo_data;
        parity_bit <= ^fifo_data;
        tx         <= 1'b0;
        busy       <= 1'b1;
        frame_done <= (state == STOP);
      end else if (state != IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
        if (bit_end) begin
          // Each transition loads tx with the level of the bit period that begins next cycle.
          case (state)
            START: begin
              state   <= DATA;
              bit_idx <= '0;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
            DATA: begin
              if (bit_idx == IDX_LAST) begin
                if (PARITY_EN != 0) begin
                  state <= PARITY;
                  tx    <= parity_bit;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + IW'(1);
                tx      <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end
            PARITY: begin
              state <= STOP;
              tx    <= 1'b1;
            end
            STOP: begin
              state      <= IDLE;
              tx         <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
            default: begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a no-parity and a parity instance, each fed by a bench FIFO,
// checked every cycle against a frame-level model plus hand-computed cycle points.
module tb_fifo_serial_tx;

  localparam int DW  = 4;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  logic          fifo_empty [2];
  logic [DW-1:0] fifo_data  [2];
  logic          fifo_r_en  [2];
  logic          tx         [2];
  logic          busy       [2];
  logic          frame_done [2];

  logic [DW-1:0] mem [2][64];
  int wr_ptr [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int pops_seen [2] = '{0, 0};
  int frames_started [2] = '{0, 0};

  bit            active    [2] = '{0, 0};
  int            fstart    [2] = '{0, 0};
  logic [DW-1:0] fword     [2];
  int            fdone_at  [2] = '{-1, -1};
  bit            exp_pop_q [2] = '{0, 0};
  bit            end_now_q [2] = '{0, 0};

  int t0, t1, t2, t3, r2;

  always #5 clk = ~clk;

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
  assign fifo_data[0]  = mem[0][rd_ptr[0][5:0]];
  assign fifo_data[1]  = mem[1][rd_ptr[1][5:0]];

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]), .fifo_r_en(fifo_r_en[0]),
    .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]), .fifo_r_en(fifo_r_en[1]),
    .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  // Line level for bit slot b of a frame: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int par, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (par != 0 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d] cyc=%0d got=%0b want=%0b", name, k, cyc, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic atCycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic applyStimulus(input logic r, input logic e);
    nextCycle();
    rst_n  = r;
    enable = e;
  endtask

  task automatic pushWord(input int k, input logic [DW-1:0] w);
    mem[k][wr_ptr[k][5:0]] = w;
    wr_ptr[k]++;
  endtask

  // Frame-level model: expectations at each falling edge, FIFO pops and frame starts at each rising edge.
  initial begin : model
    int fend, nbits;
    bit inf;
    logic etx, ebusy, efd, epop;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nbits = 2 + DW + k;
        if (!rst_n) begin
          active[k]   = 1'b0;
          fdone_at[k] = -1;
          inf = 1'b0; fend = 0;
          etx = 1'b1; ebusy = 1'b0; efd = 1'b0; epop = 1'b0;
        end else begin
          fend  = fstart[k] + nbits * CPB - 1;
          inf   = active[k] && cyc >= fstart[k] && cyc <= fend;
          etx   = inf ? frame_bit(fword[k], k, (cyc - fstart[k]) / CPB) : 1'b1;
          ebusy = inf;
          efd   = (cyc == fdone_at[k]);
          epop  = enable && !fifo_empty[k] && (!inf || cyc == fend);
        end
        exp_pop_q[k] = epop;
        end_now_q[k] = inf && cyc == fend;
        checkOutput("tx", k, tx[k], etx);
        checkOutput("busy", k, busy[k], ebusy);
        checkOutput("frame_done", k, frame_done[k], efd);
        checkOutput("fifo_r_en", k, fifo_r_en[k], epop);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (fifo_r_en[k]) begin
          rd_ptr[k] <= rd_ptr[k] + 1;
          pops_seen[k]++;
        end
        if (end_now_q[k]) fdone_at[k] = cyc + 1;
        if (exp_pop_q[k]) begin
          active[k] = 1'b1;
          fstart[k] = cyc + 1;
          fword[k]  = fifo_data[k];
          frames_started[k]++;
        end
      end
      cyc <= cyc + 1;
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    pushWord(0, 4'hA);
    pushWord(1, 4'h7);
    pushWord(1, 4'h3);

    atCycle(3);
    checkOutput("rst_tx", 0, tx[0], 1'b1);
    checkOutput("rst_busy", 0, busy[0], 1'b0);
    checkOutput("rst_r_en", 0, fifo_r_en[0], 1'b0);
    checkOutput("rst_r_en", 1, fifo_r_en[1], 1'b0);
    checkOutput("rst_fd", 0, frame_done[0], 1'b0);

    atCycle(4);
    applyStimulus(1'b1, 1'b1);
    t0 = cyc;

    fork
      begin
        atCycle(t0);      checkOutput("pop_a", 0, fifo_r_en[0], 1'b1);
        atCycle(t0 + 1);  checkOutput("start_a", 0, tx[0], 1'b0);
                          checkOutput("busy_a", 0, busy[0], 1'b1);
        atCycle(t0 + 16); checkOutput("start_end_a", 0, tx[0], 1'b0);
        atCycle(t0 + 17); checkOutput("d0_a", 0, tx[0], 1'b0);
        atCycle(t0 + 33); checkOutput("d1_a", 0, tx[0], 1'b1);
        atCycle(t0 + 49); checkOutput("d2_a", 0, tx[0], 1'b0);
        atCycle(t0 + 65); checkOutput("d3_a", 0, tx[0], 1'b1);
        atCycle(t0 + 81); checkOutput("stop_a", 0, tx[0], 1'b1);
        atCycle(t0 + 96); checkOutput("busy_last_a", 0, busy[0], 1'b1);
                          checkOutput("fd_early_a", 0, frame_done[0], 1'b0);
        atCycle(t0 + 97); checkOutput("busy_off_a", 0, busy[0], 1'b0);
                          checkOutput("fd_a", 0, frame_done[0], 1'b1);
        atCycle(t0 + 98); checkOutput("fd_once_a", 0, frame_done[0], 1'b0);

        atCycle(t0 + 99);
        nextCycle();
        pushWord(0, 4'h3);
        pushWord(0, 4'hC);
        t1 = cyc;
        atCycle(t1);       checkOutput("pop_3", 0, fifo_r_en[0], 1'b1);
        atCycle(t1 + 17);  checkOutput("d0_3", 0, tx[0], 1'b1);
        atCycle(t1 + 95);  checkOutput("no_pop_early", 0, fifo_r_en[0], 1'b0);
        atCycle(t1 + 96);  checkOutput("pop_c", 0, fifo_r_en[0], 1'b1);
                           checkOutput("stop_3", 0, tx[0], 1'b1);
        atCycle(t1 + 97);  checkOutput("start_c", 0, tx[0], 1'b0);
                           checkOutput("busy_b2b", 0, busy[0], 1'b1);
                           checkOutput("fd_3", 0, frame_done[0], 1'b1);
        atCycle(t1 + 113); checkOutput("d0_c", 0, tx[0], 1'b0);
        atCycle(t1 + 145); checkOutput("d2_c", 0, tx[0], 1'b1);
        atCycle(t1 + 192); checkOutput("busy_end_c", 0, busy[0], 1'b1);
        atCycle(t1 + 193); checkOutput("busy_off_c", 0, busy[0], 1'b0);
                           checkOutput("fd_c", 0, frame_done[0], 1'b1);
      end
      begin
        atCycle(t0);       checkOutput("pop_7", 1, fifo_r_en[1], 1'b1);
        atCycle(t0 + 81);  checkOutput("par_7", 1, tx[1], 1'b1);
        atCycle(t0 + 96);  checkOutput("par_7_end", 1, tx[1], 1'b1);
        atCycle(t0 + 97);  checkOutput("stop_7", 1, tx[1], 1'b1);
        atCycle(t0 + 112); checkOutput("pop_3p", 1, fifo_r_en[1], 1'b1);
        atCycle(t0 + 113); checkOutput("start_3p", 1, tx[1], 1'b0);
                           checkOutput("fd_7", 1, frame_done[1], 1'b1);
        atCycle(t0 + 193); checkOutput("par_3", 1, tx[1], 1'b0);
        atCycle(t0 + 208); checkOutput("par_3_end", 1, tx[1], 1'b0);
        atCycle(t0 + 209); checkOutput("stop_3p", 1, tx[1], 1'b1);
        atCycle(t0 + 225); checkOutput("fd_3p", 1, frame_done[1], 1'b1);
                           checkOutput("busy_off_p", 1, busy[1], 1'b0);
      end
    join

    // Enable dropped mid-frame with words still queued.
    atCycle(t1 + 199);
    nextCycle();
    pushWord(0, 4'h5);
    pushWord(0, 4'h9);
    pushWord(0, 4'h6);
    t2 = cyc;
    atCycle(t2);       checkOutput("pop_5", 0, fifo_r_en[0], 1'b1);
    atCycle(t2 + 39);
    applyStimulus(1'b1, 1'b0);
    atCycle(t2 + 96);  checkOutput("no_pop_dis", 0, fifo_r_en[0], 1'b0);
                       checkOutput("busy_dis", 0, busy[0], 1'b1);
    atCycle(t2 + 97);  checkOutput("fd_5", 0, frame_done[0], 1'b1);
                       checkOutput("busy_off_dis", 0, busy[0], 1'b0);
    atCycle(t2 + 120); checkOutput("idle_r_en", 0, fifo_r_en[0], 1'b0);
                       checkOutput("idle_tx", 0, tx[0], 1'b1);
    atCycle(t2 + 129);
    applyStimulus(1'b1, 1'b1);
    t3 = cyc;
    atCycle(t3);       checkOutput("pop_9", 0, fifo_r_en[0], 1'b1);

    // Reset in the middle of the data bits of word 9.
    atCycle(t3 + 49);  checkOutput("d2_9", 0, tx[0], 1'b0);
    applyStimulus(1'b0, 1'b1);
    atCycle(t3 + 50);  checkOutput("rst_mid_tx", 0, tx[0], 1'b1);
                       checkOutput("rst_mid_busy", 0, busy[0], 1'b0);
                       checkOutput("rst_mid_r_en", 0, fifo_r_en[0], 1'b0);
    atCycle(t3 + 52);
    applyStimulus(1'b1, 1'b1);
    r2 = cyc;
    atCycle(r2);       checkOutput("pop_6", 0, fifo_r_en[0], 1'b1);
    atCycle(r2 + 17);  checkOutput("d0_6", 0, tx[0], 1'b0);
    atCycle(r2 + 33);  checkOutput("d1_6", 0, tx[0], 1'b1);
    atCycle(r2 + 97);  checkOutput("fd_6", 0, frame_done[0], 1'b1);
    atCycle(r2 + 100);

    total++;
    if (pops_seen[0] != 6) begin
      bad++;
      $display("[TB] FAIL pop_count[0] got=%0d want=6", pops_seen[0]);
    end
    total++;
    if (frames_started[0] != 6) begin
      bad++;
      $display("[TB] FAIL frames_started[0] got=%0d want=6", frames_started[0]);
    end
    total++;
    if (pops_seen[1] != 2) begin
      bad++;
      $display("[TB] FAIL pop_count[1] got=%0d want=2", pops_seen[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
